// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg : burst encodings, response codes and beat-counter width  (rev 1.0)
// ============================================================================
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } axi_burst_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int BEAT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// axi_burst_addr : combinational next-beat address for FIXED/INCR/WRAP  (rev 1.0)
// ============================================================================
module axi_burst_addr
   import axi_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [3:0]  len,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr
);

   logic [1:0]  eff_size;
   logic [31:0] step;
   logic [31:0] incr;
   logic [31:0] mask;

   always_comb begin
      eff_size = (size > 3'd2) ? 2'd2 : size[1:0];
      step     = 32'd1 << eff_size;
      incr     = addr + step;
      // wrap window is (len+1) beats; only bits inside it may change
      mask     = (({28'd0, len} + 32'd1) << eff_size) - 32'd1;
      case (axi_burst_t'(burst))
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~mask) | (incr & mask);
         default: next_addr = incr;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/axi_sram_bridge.sv
`default_nettype none
// ============================================================================
// axi_sram_bridge : AXI3 slave terminating on a 1-cycle-latency SRAM  (rev 1.0)
// ============================================================================
module axi_sram_bridge
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 4
)
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [31:0]           araddr,
   input  logic [3:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   input  logic [1:0]            arlock,
   input  logic [3:0]            arcache,
   input  logic [2:0]            arprot,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [ID_WIDTH-1:0]   rid,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [31:0]           awaddr,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awlock,
   input  logic [3:0]            awcache,
   input  logic [2:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ID_WIDTH-1:0]   wid,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_WIDTH-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, WRESP = 2'd3} state_t;

   state_t                  state;
   logic                    prio_wr;
   logic [ID_WIDTH-1:0]     id_q;
   logic [31:0]             addr_q;
   logic [3:0]              len_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [BEAT_CNT_W-1:0]   beat_q;
   logic [BEAT_CNT_W-1:0]   iss_q;
   logic                    iss_done;
   logic                    inflight;
   logic [1:0]              buf_cnt;
   logic [31:0]             buf0;
   logic [31:0]             buf1;
   logic                    resp_err;
   logic [31:0]             next_addr;

   logic ar_grant, aw_grant, rd_issue, r_hs, w_hs, w_cnt_last, pop, push;
   logic unused_ok;

   assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   assign ar_grant = (state == IDLE) && arvalid && (!awvalid || !prio_wr);
   assign aw_grant = (state == IDLE) && awvalid && (!arvalid ||  prio_wr);
   assign arready  = ar_grant;
   assign awready  = aw_grant;

   // head of the output buffer; an empty buffer forwards the beat landing from SRAM
   assign rvalid = (state == RD) && ((buf_cnt != 2'd0) || inflight);
   assign rdata  = (buf_cnt != 2'd0) ? buf0 : (inflight ? ram_rdata : 32'd0);
   assign rlast  = rvalid && (beat_q == len_q);
   assign rid    = id_q;
   assign rresp  = OKAY;
   assign r_hs   = rvalid && rready;

   assign rd_issue = (state == RD) && !iss_done && ((buf_cnt + {1'b0, inflight}) < 2'd2);
   assign pop      = r_hs && (buf_cnt != 2'd0);
   assign push     = inflight && !(r_hs && (buf_cnt == 2'd0));

   assign wready     = (state == WR);
   assign w_hs       = (state == WR) && wvalid;
   assign w_cnt_last = (beat_q == len_q);

   assign bvalid = (state == WRESP);
   assign bid    = id_q;
   assign bresp  = resp_err ? SLVERR : OKAY;

   assign ram_en    = rd_issue || w_hs;
   assign ram_we    = w_hs ? wstrb : 4'b0000;
   assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
   assign ram_wdata = wdata;

   axi_burst_addr u_burst_addr (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         prio_wr  <= 1'b0;
         id_q     <= '0;
         addr_q   <= 32'd0;
         len_q    <= 4'd0;
         size_q   <= 3'd0;
         burst_q  <= 2'd0;
         beat_q   <= '0;
         iss_q    <= '0;
         iss_done <= 1'b0;
         inflight <= 1'b0;
         buf_cnt  <= 2'd0;
         buf0     <= 32'd0;
         buf1     <= 32'd0;
         resp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               beat_q   <= '0;
               iss_q    <= '0;
               iss_done <= 1'b0;
               if (ar_grant) begin
                  id_q    <= arid;
                  addr_q  <= araddr;
                  len_q   <= arlen;
                  size_q  <= arsize;
                  burst_q <= arburst;
                  prio_wr <= 1'b1;
                  state   <= RD;
               end else if (aw_grant) begin
                  id_q     <= awid;
                  addr_q   <= awaddr;
                  len_q    <= awlen;
                  size_q   <= awsize;
                  burst_q  <= awburst;
                  prio_wr  <= 1'b0;
                  resp_err <= 1'b0;
                  state    <= WR;
               end
            end
            RD: begin
               inflight <= rd_issue;
               if (rd_issue) begin
                  addr_q <= next_addr;
                  iss_q  <= iss_q + 1'b1;
                  if (iss_q == len_q)
                     iss_done <= 1'b1;
               end
               if (pop)
                  buf0 <= buf1;
               if (push) begin
                  if (buf_cnt == {1'b0, pop})
                     buf0 <= ram_rdata;
                  else
                     buf1 <= ram_rdata;
               end
               buf_cnt <= buf_cnt - {1'b0, pop} + {1'b0, push};
               if (r_hs) begin
                  beat_q <= beat_q + 1'b1;
                  if (rlast)
                     state <= IDLE;
               end
            end
            WR: begin
               if (w_hs) begin
                  addr_q <= next_addr;
                  beat_q <= beat_q + 1'b1;
                  if (wlast != w_cnt_last)
                     resp_err <= 1'b1;
                  if (wlast || w_cnt_last)
                     state <= WRESP;
               end
            end
            WRESP: begin
               if (bready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_bridge.sv
`default_nettype none
// ============================================================================
// tb_axi_sram_bridge : scoreboard bench with SRAM model and reference memory  (rev 1.0)
// ============================================================================
module tb_axi_sram_bridge;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata, ram_wdata, ram_rdata = '0;
   logic [3:0]  arlen = '0, awlen = '0, wstrb = '0, ram_we;
   logic [2:0]  arsize = '0, awsize = '0;
   logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
   logic        arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
   logic        arready, awready, wready, rvalid, rlast, bvalid, ram_en;
   logic [15:0] ram_addr;

   axi_sram_bridge #(.ADDR_WIDTH(16), .ID_WIDTH(4)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(2'b00), .arcache(4'b0000), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(2'b00), .awcache(4'b0000), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 aclk = ~aclk;

   typedef struct {logic [31:0] data; logic last; logic [3:0] id;} rexp_t;
   typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;

   rexp_t       r_q[$];
   bexp_t       b_q[$];
   int          gl[$];
   int          r_hs_cyc[$];
   logic [31:0] sram    [0:65535];
   logic [31:0] ref_mem [0:65535];
   int n_checks = 0, n_errors = 0, cyc = 0, wr_strobes = 0, rmode = 0, bmode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // word touched by beat i, derived from the burst rules directly
   function automatic logic [15:0] beat_word(input logic [31:0] a, input int size, input int len,
                                             input int burst, input int i);
      longint unsigned step, win, base, b;
      step = 64'd1 << ((size > 2) ? 2 : size);
      case (burst)
         0: b = a;
         2: begin
            win  = (len + 1) * step;
            base = (a / win) * win;
            b    = base + ((a - base) + i * step) % win;
         end
         default: b = a + i * step;
      endcase
      return 16'(b >> 2);
   endfunction

   // SRAM: registered read data, byte-enabled write
   always @(posedge aclk) begin
      logic [31:0] rd;
      if (ram_en) begin
         rd = sram[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) sram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
         if (ram_we != 4'b0) wr_strobes = wr_strobes + 1;
         ram_rdata <= rd;
      end
   end

   always @(posedge aclk) cyc <= cyc + 1;

   always @(posedge aclk) begin
      #1;
      case (rmode)
         0: rready = 1'b1;
         1: rready = ~rready;
         2: rready = 1'($urandom_range(0, 1));
         default: rready = 1'b0;
      endcase
      case (bmode)
         0: bready = 1'b1;
         2: bready = 1'($urandom_range(0, 1));
         default: bready = 1'b0;
      endcase
   end

   // R monitor: stability under stall and scoreboard pop on handshake
   logic        r_stall = 0, st_last = 0;
   logic [31:0] st_data = '0;
   always @(negedge aclk) begin
      rexp_t e;
      if (!aresetn) r_stall = 1'b0;
      else begin
         if (r_stall) begin
            check("r_stable_valid", rvalid, 1);
            check("r_stable_data", rdata, st_data);
            check("r_stable_last", rlast, st_last);
         end
         if (rvalid && rready) begin
            r_hs_cyc.push_back(cyc);
            if (r_q.size() == 0) check("r_unexpected_beat", rvalid, 0);
            else begin
               e = r_q.pop_front();
               check("r_data", rdata, e.data);
               check("r_last", rlast, e.last);
               check("r_id", rid, e.id);
               check("r_resp", rresp, 0);
            end
         end
         r_stall = rvalid && !rready;
         st_data = rdata;
         st_last = rlast;
      end
   end

   // B monitor and grant log
   always @(negedge aclk) begin
      bexp_t e;
      if (aresetn) begin
         if (bvalid && bready) begin
            if (b_q.size() == 0) check("b_unexpected", bvalid, 0);
            else begin
               e = b_q.pop_front();
               check("b_id", bid, e.id);
               check("b_resp", bresp, e.resp);
            end
         end
         if (arready && awready) check("grant_exclusive", {arready, awready}, 2'b10);
         if (arvalid && arready) gl.push_back(0);
         if (awvalid && awready) gl.push_back(1);
      end
   end

   task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                          input int size, input int burst);
      int n;
      rexp_t e;
      arid = id; araddr = a; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
      arvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < 1000);
      if (!arready) begin check("ar_timeout", arready, 1); arvalid = 1'b0; return; end
      for (int i = 0; i <= len; i++) begin
         e.data = ref_mem[beat_word(a, size, len, burst, i)];
         e.last = (i == len);
         e.id   = id;
         r_q.push_back(e);
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input int burst, input int lastb,
                           input logic [31:0] d0, input logic [3:0] s0, input bit rnd, input bit chk);
      int n, nb;
      bit err;
      logic [31:0] d;
      logic [3:0] s;
      logic [15:0] w;
      bexp_t e;
      err = (lastb != len);
      nb  = (lastb < len) ? lastb + 1 : len + 1;
      awid = id; awaddr = a; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!awready && n < 1000);
      if (!awready) begin check("aw_timeout", awready, 1); awvalid = 1'b0; return; end
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
         d = rnd ? $urandom : d0;
         s = rnd ? 4'($urandom) : s0;
         wdata = d; wstrb = s; wlast = (i == lastb); wvalid = 1'b1;
         n = 0;
         do begin @(negedge aclk); n++; end while (!wready && n < 1000);
         if (chk && i == 0) check("wready_latency", n, 1);
         if (!wready) begin check("w_timeout", wready, 1); wvalid = 1'b0; return; end
         w = beat_word(a, size, len, burst, i);
         for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
         if (i == nb - 1) begin
            e.id = id;
            e.resp = err ? 2'b10 : 2'b00;
            b_q.push_back(e);
         end
         @(posedge aclk); #1;
         wvalid = 1'b0; wlast = 1'b0;
      end
      if (chk) begin
         @(negedge aclk);
         check("bvalid_latency", bvalid, 1);
         @(posedge aclk); #1;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((r_q.size() != 0 || b_q.size() != 0) && n < 3000) begin @(posedge aclk); n++; end
      check("drain_timeout", n < 3000, 1);
      @(posedge aclk); #1;
   endtask

   task automatic rand_params(output int len, output int size, output int burst, output logic [31:0] a);
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 3);
      len   = (burst == 2) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
      a     = 32'($urandom_range(0, 32'h3FFFF));
      a     = a & ~((32'd1 << ((size > 2) ? 2 : size)) - 32'd1);
   endtask

   task automatic rand_read();
      int len, size, burst;
      logic [31:0] a;
      rand_params(len, size, burst, a);
      do_read(4'($urandom), a, len, size, burst);
   endtask

   task automatic rand_write();
      int len, size, burst, lastb;
      logic [31:0] a;
      rand_params(len, size, burst, a);
      lastb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : len;
      do_write(4'($urandom), a, len, size, burst, lastb, 32'd0, 4'd0, 1'b1, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

   initial begin
      int base_strobes, mism, hits;
      for (int i = 0; i < 65536; i++) begin
         sram[i] = $urandom;
         ref_mem[i] = sram[i];
      end
      repeat (3) @(negedge aclk);
      check("rst_arready", arready, 0);  check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);    check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);    check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);    check("rst_rdata", rdata, 0);
      check("rst_rid", rid, 0);          check("rst_bid", bid, 0);
      check("rst_bresp", bresp, 0);      check("rst_rresp", rresp, 0);
      check("rst_rlast", rlast, 0);
      @(posedge aclk); #1; aresetn = 1'b1;
      @(posedge aclk); #1;

      // single read with latency probe
      sram[16'h40] = 32'hDEADBEEF; ref_mem[16'h40] = 32'hDEADBEEF;
      do_read(4'h5, 32'h100, 0, 2, 1);
      @(negedge aclk);
      check("rd_c1_ram_en", ram_en, 1); check("rd_c1_ram_addr", ram_addr, 16'h40);
      check("rd_c1_rvalid", rvalid, 0);
      @(negedge aclk);
      check("rd_c2_rvalid", rvalid, 1); check("rd_c2_rdata", rdata, 32'hDEADBEEF);
      check("rd_c2_rlast", rlast, 1);   check("rd_c2_rid", rid, 4'h5);
      @(posedge aclk); #1;
      wait_done();

      // INCR read with rready toggling, then full-rate throughput
      rmode = 1;
      do_read(4'h3, 32'h200, 7, 2, 1);
      wait_done();
      rmode = 0;
      r_hs_cyc.delete();
      do_read(4'h9, 32'h1000, 7, 2, 1);
      wait_done();
      check("thru_beats", r_hs_cyc.size(), 8);
      if (r_hs_cyc.size() == 8) check("thru_span", r_hs_cyc[7] - r_hs_cyc[0], 7);

      // WRAP write
      do_write(4'h2, 32'h38, 3, 2, 2, 3, 32'd0, 4'd0, 1'b1, 1'b0);
      wait_done();
      for (int k = 12; k < 16; k++) check("wrap_word", sram[k], ref_mem[k]);

      // byte strobes over existing data, with write timing probes
      sram[16'hC0] = 32'hAABBCCDD; ref_mem[16'hC0] = 32'hAABBCCDD;
      do_write(4'h7, 32'h300, 0, 2, 1, 0, 32'h11223344, 4'b0101, 1'b0, 1'b1);
      wait_done();
      check("strobe_merge", sram[16'hC0], 32'hAA22CC44);

      // early wlast then missing wlast, both SLVERR
      base_strobes = wr_strobes;
      do_write(4'hA, 32'h400, 3, 2, 1, 1, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0);
      wait_done();
      check("early_wlast_beats", wr_strobes - base_strobes, 2);
      base_strobes = wr_strobes;
      do_write(4'hB, 32'h500, 2, 2, 1, 99, 32'h0F0F0F0F, 4'hF, 1'b0, 1'b0);
      wait_done();
      check("no_wlast_beats", wr_strobes - base_strobes, 3);

      // contention: both address channels held valid
      rmode = 2; bmode = 2;
      gl.delete();
      fork
         begin for (int k = 0; k < 4; k++) rand_read(); end
         begin for (int k = 0; k < 4; k++) rand_write(); end
      join
      wait_done();
      check("grant_count", gl.size(), 8);
      for (int k = 0; k < gl.size() && k < 8; k++) check("grant_order", gl[k], k % 2);

      // randomized mix
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 1) rand_read(); else rand_write();
      end
      wait_done();

      // reset mid read burst
      rmode = 3;
      do_read(4'h6, 32'h2000, 15, 2, 1);
      repeat (4) begin @(posedge aclk); #1; end
      @(negedge aclk);
      check("stall_rvalid", rvalid, 1);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(negedge aclk);
      check("arst_valids", {arready, awready, wready, rvalid, bvalid, ram_en}, 6'b0);
      r_q.delete();
      @(posedge aclk); #1; aresetn = 1'b1;
      rmode = 0; bmode = 0;
      hits = 0;
      repeat (20) begin @(negedge aclk); if (rvalid || bvalid) hits++; end
      check("no_resp_after_reset", hits, 0);
      @(posedge aclk); #1;
      do_read(4'hC, 32'h104, 3, 2, 1);
      wait_done();

      mism = 0;
      for (int i = 0; i < 65536; i++) if (sram[i] !== ref_mem[i]) mism++;
      check("memory_image", mism, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_sram_bridge.md
# axi_sram_bridge

AXI3 slave that terminates the core's 32-bit memory bus and drives a single-port synchronous SRAM with 1-cycle read latency. It sits directly downstream of `mycpu_top`'s AXI master port, as the simulation and FPGA memory endpoint. It serves one transaction at a time, with round-robin arbitration between the read and write address channels. It supports FIXED, INCR and WRAP bursts of up to 16 beats.

## Interface
- `ADDR_WIDTH`, 16: SRAM word-address width; byte-address bits `[ADDR_WIDTH+1:2]` select the word.
- `ID_WIDTH`, 4: AXI ID width.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`  in  ID_WIDTH/32/4/3/2  read address; `arlock`/`arcache`/`arprot` in, ignored.
- `arvalid` in 1, `arready` out 1  AR handshake.
- `rid`/`rdata`/`rresp`/`rlast`  out  ID_WIDTH/32/2/1  read data; `rvalid` out 1, `rready` in 1.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`  in  ID_WIDTH/32/4/3/2  write address; `awlock`/`awcache`/`awprot` in, ignored.
- `awvalid` in 1, `awready` out 1  AW handshake.
- `wid`/`wdata`/`wstrb`/`wlast`  in  ID_WIDTH/32/4/1  write data; `wid` is ignored. `wvalid` in 1, `wready` out 1.
- `bid`/`bresp`  out  ID_WIDTH/2  write response; `bvalid` out 1, `bready` in 1.
- `ram_en`  out  1  SRAM access strobe.
- `ram_we`  out  4  byte write enables; zero means a read.
- `ram_addr`  out  ADDR_WIDTH  word address.
- `ram_wdata`  out  32.
- `ram_rdata`  in  32  valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, RD, WR, WRESP.
- IDLE: `arready` = `arvalid && (!awvalid || prio==RD)`; `awready` = `awvalid && (!arvalid || prio==WR)`. At most one is high. `prio` flips to the other type on each grant. Reset value is `prio`=RD.
- On grant, latch id, address, len, size and burst. AR grant goes to RD; AW grant goes to WR.
- Address step is `1<<size`. `size`>2 is treated as 2.
- FIXED burst: the address is constant.
- INCR burst: the address increments by the step.
- WRAP burst: the address wraps within an aligned window of `(len+1)<<size` bytes; only the low bits inside the window change.
- RD: issue SRAM reads into a 2-entry output buffer. A read is issued only when buffered beats plus in-flight beats < 2.
- RD outputs: `rresp`=OKAY; `rlast` on beat `len`; `rid` = latched id.
- RD exit: the state returns to IDLE after the handshake of the `rlast` beat.
- WR: `wready`=1. Each W handshake drives `ram_en`=1, `ram_we`=`wstrb` and `ram_wdata`=`wdata` in the same cycle.
- WR beat count: the beat counter ends the burst at beat `len`.
- WR exit: go to WRESP after beat `len` is handshaken, or earlier if `wlast` arrives.
- WR response code: SLVERR (2'b10) if `wlast` disagrees with the count at any beat, otherwise OKAY.
- WRESP: `bvalid`=1 with the latched `bid` until `bready`, then IDLE.
- A `wstrb`=0 beat is still counted and drives `ram_en`=1 with `ram_we`=0, a harmless read.

## Timing
- Reset values: `arready`, `awready`, `wready`, `rvalid`, `bvalid`, `ram_en`, `ram_we` = 0. `rdata`, `rid`, `bid`, `bresp`, `rresp`, `rlast` = 0. State is IDLE.
- Reset asserted mid-burst aborts the transaction immediately. No response is ever issued for it.
- Read latency: AR handshake at edge 0, `ram_en` in cycle 1, `rvalid` with beat 0 in cycle 2.
- Read throughput: with `rready` held high, one beat per cycle.
- Read backpressure: `rready` low stalls issue, and the SRAM beat already in flight lands in the second buffer entry. No beat is lost or duplicated.
- Output stability: `rvalid`, `rdata` and `rlast` are stable while `rvalid && !rready`.
- Write: AW handshake at edge 0 → `wready` from cycle 1. Last W handshake in cycle k → `bvalid` in cycle k+1.
- After the final R or B handshake, the FSM is in IDLE the next cycle. A new grant is possible in that same cycle.

## Structure
- The shared package `axi_pkg` holds:
  - the `axi_burst_t` enum (FIXED=0, INCR=1, WRAP=2);
  - the response constants OKAY=0 and SLVERR=2;
  - the beat-counter width.
- One sub-module, `axi_burst_addr`, is combinational next-address logic. It maps address, size, len and burst to the next address and is shared by the RD and WR paths.

## Test plan
- Single read: AR addr 0x100, len 0, SRAM word 0x40=0xDEADBEEF → `rvalid` in cycle 2 with `rdata` 0xDEADBEEF, `rlast`=1, `rid` equal to `arid`.
- INCR read: addr 0x200, len 7, size 2, `rready` toggling every cycle → 8 beats from words 0x80..0x87 in order, no gaps beyond backpressure, `rlast` only on the 8th beat.
- WRAP write: addr 0x38, len 3, size 2 → SRAM words 0x0E, 0x0F, 0x0C, 0x0D written, then `bresp` OKAY.
- Byte strobes: write 0x11223344 with `wstrb` 4'b0101 over an existing 0xAABBCCDD → SRAM holds 0xAA22CC44.
- Early `wlast`: len 3 but `wlast` on beat 1 → 2 words written, `bresp` SLVERR, FSM back in IDLE.
- Contention and reset:
  - `arvalid` and `awvalid` both high continuously → grants alternate R, W, R, W.
  - `aresetn` pulsed low mid-burst → all valids drop at once, no R or B response follows.
